easy_fifo_burst_reader: RTL and testbench

// - Read-side consumer for easy_fifo_* FIFOs (first-word-fall-through read port: rd_data valid whenever ~rd_empty, rd_en pops).
// - Drains the FIFO in bursts of up to BURST_LEN words and presents them as a valid/ready stream with an m_last marker per burst.
// - Sits in the read clock domain, between a FIFO read port and a downstream packetising sink.

---
 rtl/easy_fifo_burst_reader.sv | 112 +++++++++++
 tb/tb_easy_fifo_burst_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/easy_fifo_burst_reader.sv
// easy_fifo_burst_reader: drains a FWFT FIFO in bursts of up to BURST_LEN words onto a valid/ready stream.
// Optional idle timeout for partial bursts is enabled by defining EASY_FIFO_BURST_TIMEOUT_EN.
module easy_fifo_burst_reader #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   fifo_rd_en,
    input  logic [DWIDTH-1:0]      fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [$clog2(DEPTH):0] fifo_cnt,
    input  logic                   flush,
    output logic [DWIDTH-1:0]      m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int FW = $clog2(DEPTH) + 1;

    if (BURST_LEN < 1 || BURST_LEN > DEPTH || TIMEOUT < 2) begin : g_bad_cfg
        $error("easy_fifo_burst_reader: bad parameters");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q;
    logic [CW-1:0]     burst_q, popped_q, accepted_q, burst_d;
    logic [DWIDTH-1:0] d0_q, d1_q;
    logic              l0_q, l1_q, v0_q, v1_q;
    logic              accept, pop_last, full_cnt, start, timeout;

    assign full_cnt   = fifo_cnt >= FW'(BURST_LEN);
    assign burst_d    = full_cnt ? CW'(BURST_LEN) : (fifo_cnt == '0 ? CW'(1) : CW'(fifo_cnt));
    assign start      = full_cnt | (flush & ~fifo_rd_empty) | timeout;
    // Entry 1 is only ever occupied while the head is, so ~v1_q means fewer than 2 held words.
    assign fifo_rd_en = (state_q == BURST) & ~fifo_rd_empty & (popped_q < burst_q) & ~v1_q;
    assign accept     = v0_q & m_ready;
    assign pop_last   = popped_q + CW'(1) == burst_q;
    assign m_data     = d0_q;
    assign m_valid    = v0_q;
    assign m_last     = l0_q;
    assign busy       = state_q == BURST;

`ifdef EASY_FIFO_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] idle_q;
    logic          idle_inc;
    assign idle_inc = (state_q == IDLE) & ~fifo_rd_empty & ~full_cnt;
    assign timeout  = idle_inc & (idle_q == TW'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= (idle_inc & ~start) ? idle_q + TW'(1) : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            popped_q   <= '0;
            accepted_q <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                state_q    <= BURST;
                burst_q    <= burst_d;
                popped_q   <= '0;
                accepted_q <= '0;
            end
        end else begin
            if (fifo_rd_en) popped_q <= popped_q + CW'(1);
            if (accept) accepted_q <= accepted_q + CW'(1);
            if (accept && accepted_q + CW'(1) == burst_q) state_q <= IDLE;
        end
    end

    // Accept shifts entry 1 to the head; a pop then lands in the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= '0;
            d1_q <= '0;
            l0_q <= 1'b0;
            l1_q <= 1'b0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            if (accept) begin
                d0_q <= d1_q;
                l0_q <= l1_q;
                v0_q <= v1_q;
                v1_q <= 1'b0;
            end
            if (fifo_rd_en) begin
                if (!v0_q || accept) begin
                    d0_q <= fifo_rd_data;
                    l0_q <= pop_last;
                    v0_q <= 1'b1;
                end else begin
                    d1_q <= fifo_rd_data;
                    l1_q <= pop_last;
                    v1_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_easy_fifo_burst_reader.sv
// tb_easy_fifo_burst_reader: randomized bench with a FIFO model and a burst-chunking reference model.
module tb_easy_fifo_burst_reader;
    localparam int DW = 32, DEPTH = 16, BL = 4, TO = 8;
`ifdef EASY_FIFO_BURST_TIMEOUT_EN
    localparam int NW = 3;
`else
    localparam int NW = 2;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, m_ready = 1'b0;
    logic          fifo_rd_en, fifo_rd_empty, m_valid, m_last, busy;
    logic [DW-1:0] fifo_rd_data, m_data;
    logic [4:0]    fifo_cnt;
    logic [DW-1:0] mem [256];
    int            wp = 0, rp = 0, pops_total = 0;

    always #5 clk = ~clk;

    easy_fifo_burst_reader #(.DWIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_cnt(fifo_cnt), .flush(flush), .m_data(m_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy));

    assign fifo_rd_empty = (wp == rp);
    assign fifo_cnt      = 5'(wp - rp);
    assign fifo_rd_data  = mem[rp % 256];

    always @(posedge clk) if (fifo_rd_en) begin
        rp         <= rp + 1;
        pops_total <= pops_total + 1;
    end

    int            n_chk = 0, n_fail = 0;
    logic [DW-1:0] got_d[$], exp_d[$];
    bit            got_l[$], exp_l[$];
    int            acc_cyc[$];
    int            cyc, first_pop, first_val, first_busy, hold_err, max_occ, acc_total = 0;
    logic          pv, pr, pl;
    logic [DW-1:0] pd;

    task automatic clear_mon();
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete(); acc_cyc.delete();
        cyc = 0; first_pop = -1; first_val = -1; first_busy = -1; hold_err = 0; max_occ = 0; pv = 1'b0;
    endtask

    task automatic push_words(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) mem[(wp + i) % 256] = $urandom;
        wp = wp + n;
    endtask

    // Expected stream: FIFO contents cut into chunks of BL; a tail chunk only if partial bursts can start.
    task automatic model(input int base, input int n, input bit partial);
        int rem, idx, b;
        rem = n; idx = base;
        while (rem >= BL || (partial && rem > 0)) begin
            b = rem < BL ? rem : BL;
            for (int j = 0; j < b; j++) begin
                exp_d.push_back(mem[(idx + j) % 256]);
                exp_l.push_back(j == b - 1);
            end
            idx += b; rem -= b;
        end
    endtask

    task automatic collect(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_ready = mode == 0 ? 1'b1 : mode == 1 ? ~m_ready : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (fifo_rd_en && first_pop < 0) first_pop = cyc;
            if (m_valid && first_val < 0) first_val = cyc;
            if (busy && first_busy < 0) first_busy = cyc;
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) hold_err++;
            if (pops_total - acc_total > max_occ) max_occ = pops_total - acc_total;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data); got_l.push_back(m_last); acc_cyc.push_back(cyc); acc_total++;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if ({m_valid, m_last, busy, fifo_rd_en} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {m_valid, m_last, busy, fifo_rd_en}); end
        n_chk++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_burst();
        int base;
        clear_mon(); base = wp;
        push_words(8); model(base, 8, 1'b0);
        collect(30, 0);
        n_chk++; if (got_d.size() != exp_d.size()) begin n_fail++;
            $display("FAIL burst_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL burst_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        n_chk++; if (first_val - first_pop != 1) begin n_fail++;
            $display("FAIL burst_latency: got %0d want 1", first_val - first_pop); end
        n_chk++; if (acc_cyc.size() < 8 || acc_cyc[3] - acc_cyc[0] != 3 || acc_cyc[7] - acc_cyc[4] != 3) begin
            n_fail++; $display("FAIL burst_throughput: accepted %0d beats, not 1 per cycle", acc_cyc.size()); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle: busy %b want 0", busy); end
    endtask

    task automatic test_stall();
        int base;
        clear_mon(); base = wp;
        push_words(4); model(base, 4, 1'b0);
        collect(30, 1);
        n_chk++; if (got_d.size() != exp_d.size()) begin n_fail++;
            $display("FAIL stall_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        n_chk++; if (hold_err != 0) begin n_fail++; $display("FAIL stall_hold: %0d changes while stalled, want 0", hold_err); end
        n_chk++; if (max_occ > 2) begin n_fail++; $display("FAIL stall_occupancy: got %0d want <=2", max_occ); end
    endtask

    task automatic test_partial();
        int base;
        clear_mon(); base = wp;
        push_words(NW);
`ifdef EASY_FIFO_BURST_TIMEOUT_EN
        model(base, NW, 1'b1);
        collect(30, 0);
        n_chk++; if (first_busy != TO) begin n_fail++;
            $display("FAIL timeout_start: busy after %0d cycles want %0d", first_busy, TO); end
`else
        collect(40, 0);
        n_chk++; if (got_d.size() != 0 || first_busy >= 0) begin n_fail++;
            $display("FAIL idle_hold: beats %0d busy_at %0d want 0 and -1", got_d.size(), first_busy); end
        clear_mon(); model(base, NW, 1'b1);
        flush = 1'b1; collect(1, 0); flush = 1'b0;
        collect(20, 0);
`endif
        n_chk++; if (got_d.size() != exp_d.size()) begin n_fail++;
            $display("FAIL partial_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL partial_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_idle: busy %b want 0", busy); end
    endtask

    task automatic test_random();
        int base, n;
        for (int it = 0; it < 3; it++) begin
            clear_mon(); base = wp; n = $urandom_range(1, 16);
            push_words(n); model(base, n, 1'b1);
            flush = 1'b1; collect(150, 2); flush = 1'b0;
            n_chk++; if (got_d.size() != exp_d.size()) begin n_fail++;
                $display("FAIL rand%0d_count: got %0d want %0d", it, got_d.size(), exp_d.size()); end
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b", it, i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
            end
            n_chk++; if (hold_err != 0 || max_occ > 2) begin n_fail++;
                $display("FAIL rand%0d_skid: hold_err %0d occ %0d want 0 and <=2", it, hold_err, max_occ); end
        end
    endtask

    task automatic test_reset_mid();
        int head;
        clear_mon();
        push_words(8);
        for (int i = 0; i < 50 && got_d.size() < 2; i++) collect(1, 0);
        n_chk++; if (got_d.size() != 2) begin n_fail++; $display("FAIL rst_mid_wait: got %0d beats want 2", got_d.size()); end
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        n_chk++; if ({m_valid, m_last, busy, fifo_rd_en} !== 4'b0 || m_data !== '0) begin n_fail++;
            $display("FAIL rst_mid_outputs: got %b data %h want 0000 data 0", {m_valid, m_last, busy, fifo_rd_en}, m_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_total = pops_total;
        head = rp;
        clear_mon(); model(head, wp - head, 1'b1);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: busy %b want 0", busy); end
        flush = 1'b1; collect(60, 0); flush = 1'b0;
        n_chk++; if (got_d.size() != exp_d.size()) begin n_fail++;
            $display("FAIL rst_mid_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL rst_mid_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_stall();
        test_partial();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
